// File: rtl/ram_drain_pkg.sv
// Shared types and default sizing for the RAM drain block.
package ram_drain_pkg;

  localparam int DEF_ADDRWIDTH = 3;
  localparam int DEF_DATAWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

endpackage

// File: rtl/ram_drain_rr_pick.sv
// Round-robin first-set finder: returns the first set bit of bitmap
// searching ptr, ptr+1, ... and wrapping from DEPTH-1 back to 0.
module rr_pick #(
  parameter int AW    = 3,
  parameter int DEPTH = 2**AW
) (
  input  logic [DEPTH-1:0] bitmap,
  input  logic [AW-1:0]    ptr,
  output logic [AW-1:0]    index,
  output logic             found
);

  logic [AW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      cand = ptr + AW'(i);
      if (bitmap[cand]) begin
        index = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_drain.sv
// Drains valid RAM words one at a time: pick an address round-robin,
// read it, present the word, and clear its valid bit on handshake.
module ram_drain
  import ram_drain_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      EN,
  input  logic [(2**ADDRWIDTH)-1:0] V_IN,
  input  logic [DATAWIDTH-1:0]      RDATA,
  output logic                      RD,
  output logic [ADDRWIDTH-1:0]      ADDR,
  output logic                      CLR,
  output logic [DATAWIDTH-1:0]      DOUT,
  output logic                      DOUT_VALID,
  input  logic                      DOUT_READY,
  output logic [ADDRWIDTH-1:0]      PTR,
  output logic                      BUSY
);

  state_e                 state_q, state_d;
  logic                   rd_q, rd_d;
  logic                   busy_q, busy_d;
  logic                   dout_valid_q, dout_valid_d;
  logic [DATAWIDTH-1:0]   dout_q, dout_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [ADDRWIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDRWIDTH-1:0]   pick_idx;
  logic                   pick_found;
  logic                   handshake;

  rr_pick #(
    .AW    (ADDRWIDTH),
    .DEPTH (2**ADDRWIDTH)
  ) u_pick (
    .bitmap (V_IN),
    .ptr    (ptr_q),
    .index  (pick_idx),
    .found  (pick_found)
  );

  // dout_valid_q is only ever set in PRESENT, so this is the PRESENT handshake.
  assign handshake = dout_valid_q & DOUT_READY;

  // Next-state and next-output computation for the drain FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ptr_d        = ptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    rd_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN && pick_found) begin
          state_d = ST_ISSUE;
          addr_d  = pick_idx;
          rd_d    = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // RAM returns data the cycle after the strobe.
        dout_d       = RDATA;
        dout_valid_d = 1'b1;
        state_d      = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (handshake) begin
          dout_valid_d = 1'b0;
          ptr_d        = addr_q + ADDRWIDTH'(1);
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs; reset discards any in-flight word.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      addr_q       <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      addr_q       <= addr_d;
      ptr_q        <= ptr_d;
    end
  end

  assign RD         = rd_q;
  assign BUSY       = busy_q;
  assign DOUT_VALID = dout_valid_q;
  assign DOUT       = dout_q;
  assign ADDR       = addr_q;
  assign PTR        = ptr_q;
  // Clear must land in the handshake cycle itself, so it cannot be registered.
  assign CLR        = handshake;

endmodule

// File: tb/tb_ram_drain.sv
// Directed bench for ram_drain with a one-cycle-latency RAM read model.
module tb_ram_drain;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] V_IN = 8'h00;
  logic [7:0] RDATA;
  logic       RD;
  logic [2:0] ADDR;
  logic       CLR;
  logic [7:0] DOUT;
  logic       DOUT_VALID;
  logic       DOUT_READY = 1'b0;
  logic [2:0] PTR;
  logic       BUSY;

  logic [7:0] mem [8];
  logic       rd_d1 = 1'b0;
  logic [2:0] addr_d1 = 3'd0;
  int         vecs = 0;
  int         errs = 0;

  ram_drain #(.ADDRWIDTH(3), .DATAWIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .V_IN(V_IN), .RDATA(RDATA),
    .RD(RD), .ADDR(ADDR), .CLR(CLR), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY), .PTR(PTR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // RAM model: data for the strobed address appears one cycle after RD.
  always @(posedge CLK) begin
    rd_d1   <= RD;
    addr_d1 <= ADDR;
  end
  assign RDATA = rd_d1 ? mem[addr_d1] : 8'hEE;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; EN = 1'b0; V_IN = 8'h00; DOUT_READY = 1'b0;
    tick(); tick();
    vecs++; if (RD !== 1'b0)         begin errs++; $display("FAIL reset_rd: got %b want 0", RD); end
    vecs++; if (CLR !== 1'b0)        begin errs++; $display("FAIL reset_clr: got %b want 0", CLR); end
    vecs++; if (DOUT_VALID !== 1'b0) begin errs++; $display("FAIL reset_dv: got %b want 0", DOUT_VALID); end
    vecs++; if (DOUT !== 8'h00)      begin errs++; $display("FAIL reset_dout: got %h want 00", DOUT); end
    vecs++; if (ADDR !== 3'd0)       begin errs++; $display("FAIL reset_addr: got %0d want 0", ADDR); end
    vecs++; if (PTR !== 3'd0)        begin errs++; $display("FAIL reset_ptr: got %0d want 0", PTR); end
    vecs++; if (BUSY !== 1'b0)       begin errs++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    RESET = 1'b1;
    tick();
    vecs++; if (BUSY !== 1'b0)       begin errs++; $display("FAIL idle_en0_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_single();
    V_IN = 8'h04; EN = 1'b1; DOUT_READY = 1'b1;
    tick();
    vecs++; if (RD !== 1'b1)   begin errs++; $display("FAIL single_rd: got %b want 1", RD); end
    vecs++; if (ADDR !== 3'd2) begin errs++; $display("FAIL single_addr: got %0d want 2", ADDR); end
    vecs++; if (BUSY !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", BUSY); end
    vecs++; if (CLR !== 1'b0)  begin errs++; $display("FAIL single_clr_issue: got %b want 0", CLR); end
    tick();
    vecs++; if (RD !== 1'b0)         begin errs++; $display("FAIL single_rd_wait: got %b want 0", RD); end
    vecs++; if (DOUT_VALID !== 1'b0) begin errs++; $display("FAIL single_dv_wait: got %b want 0", DOUT_VALID); end
    tick();
    vecs++; if (DOUT_VALID !== 1'b1) begin errs++; $display("FAIL single_dv: got %b want 1", DOUT_VALID); end
    vecs++; if (DOUT !== 8'hA5)      begin errs++; $display("FAIL single_dout: got %h want a5", DOUT); end
    vecs++; if (CLR !== 1'b1)        begin errs++; $display("FAIL single_clr: got %b want 1", CLR); end
    vecs++; if (ADDR !== 3'd2)       begin errs++; $display("FAIL single_clr_addr: got %0d want 2", ADDR); end
    V_IN = 8'h00;
    tick();
    vecs++; if (PTR !== 3'd3)        begin errs++; $display("FAIL single_ptr: got %0d want 3", PTR); end
    vecs++; if (BUSY !== 1'b0)       begin errs++; $display("FAIL single_idle: got %b want 0", BUSY); end
    vecs++; if (CLR !== 1'b0)        begin errs++; $display("FAIL single_clr_after: got %b want 0", CLR); end
  endtask

  task automatic test_round_robin();
    // Move PTR from 3 to 5 by serving address 4.
    V_IN = 8'h10; EN = 1'b1; DOUT_READY = 1'b1;
    tick(); tick(); tick();
    V_IN = 8'h00;
    tick();
    vecs++; if (PTR !== 3'd5) begin errs++; $display("FAIL rr_ptr_setup: got %0d want 5", PTR); end
    V_IN = 8'h21;
    tick();
    vecs++; if (ADDR !== 3'd5) begin errs++; $display("FAIL rr_first_addr: got %0d want 5", ADDR); end
    tick(); tick();
    vecs++; if (DOUT !== 8'h55) begin errs++; $display("FAIL rr_first_dout: got %h want 55", DOUT); end
    vecs++; if (CLR !== 1'b1)   begin errs++; $display("FAIL rr_first_clr: got %b want 1", CLR); end
    V_IN = 8'h01;
    tick();
    vecs++; if (PTR !== 3'd6)  begin errs++; $display("FAIL rr_mid_ptr: got %0d want 6", PTR); end
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL rr_mid_idle: got %b want 0", BUSY); end
    tick();
    vecs++; if (ADDR !== 3'd0) begin errs++; $display("FAIL rr_second_addr: got %0d want 0", ADDR); end
    vecs++; if (RD !== 1'b1)   begin errs++; $display("FAIL rr_second_rd: got %b want 1", RD); end
    tick(); tick();
    vecs++; if (DOUT !== 8'h0F) begin errs++; $display("FAIL rr_second_dout: got %h want 0f", DOUT); end
    V_IN = 8'h00;
    tick();
    vecs++; if (PTR !== 3'd1) begin errs++; $display("FAIL rr_end_ptr: got %0d want 1", PTR); end
  endtask

  task automatic test_wrap();
    RESET = 1'b0; EN = 1'b0;
    tick(); tick();
    RESET = 1'b1;
    V_IN = 8'h80; EN = 1'b1; DOUT_READY = 1'b1;
    tick();
    vecs++; if (ADDR !== 3'd7) begin errs++; $display("FAIL wrap_addr: got %0d want 7", ADDR); end
    tick(); tick();
    vecs++; if (DOUT !== 8'h77) begin errs++; $display("FAIL wrap_dout: got %h want 77", DOUT); end
    vecs++; if (CLR !== 1'b1)   begin errs++; $display("FAIL wrap_clr: got %b want 1", CLR); end
    V_IN = 8'h00;
    tick();
    vecs++; if (PTR !== 3'd0) begin errs++; $display("FAIL wrap_ptr: got %0d want 0", PTR); end
  endtask

  task automatic test_backpressure();
    V_IN = 8'h02; EN = 1'b1; DOUT_READY = 1'b0;
    tick(); tick(); tick();
    // The valid bit disappearing after selection must not abort the word.
    V_IN = 8'h00;
    for (int i = 0; i < 10; i++) begin
      vecs++; if (DOUT_VALID !== 1'b1) begin errs++; $display("FAIL bp_dv[%0d]: got %b want 1", i, DOUT_VALID); end
      vecs++; if (DOUT !== 8'h3C)      begin errs++; $display("FAIL bp_dout[%0d]: got %h want 3c", i, DOUT); end
      vecs++; if (ADDR !== 3'd1)       begin errs++; $display("FAIL bp_addr[%0d]: got %0d want 1", i, ADDR); end
      vecs++; if (CLR !== 1'b0)        begin errs++; $display("FAIL bp_clr[%0d]: got %b want 0", i, CLR); end
      tick();
    end
    DOUT_READY = 1'b1;
    #1;
    vecs++; if (CLR !== 1'b1)  begin errs++; $display("FAIL bp_clr_rise: got %b want 1", CLR); end
    vecs++; if (ADDR !== 3'd1) begin errs++; $display("FAIL bp_clr_addr: got %0d want 1", ADDR); end
    tick();
    vecs++; if (PTR !== 3'd2)        begin errs++; $display("FAIL bp_ptr: got %0d want 2", PTR); end
    vecs++; if (DOUT_VALID !== 1'b0) begin errs++; $display("FAIL bp_dv_after: got %b want 0", DOUT_VALID); end
    vecs++; if (CLR !== 1'b0)        begin errs++; $display("FAIL bp_clr_after: got %b want 0", CLR); end
  endtask

  task automatic test_en_drop();
    V_IN = 8'hFF; EN = 1'b1; DOUT_READY = 1'b1;
    tick();
    vecs++; if (ADDR !== 3'd2) begin errs++; $display("FAIL en_addr: got %0d want 2", ADDR); end
    tick();
    EN = 1'b0;
    tick();
    vecs++; if (DOUT_VALID !== 1'b1) begin errs++; $display("FAIL en_dv: got %b want 1", DOUT_VALID); end
    vecs++; if (DOUT !== 8'hA5)      begin errs++; $display("FAIL en_dout: got %h want a5", DOUT); end
    vecs++; if (CLR !== 1'b1)        begin errs++; $display("FAIL en_clr: got %b want 1", CLR); end
    tick();
    vecs++; if (PTR !== 3'd3) begin errs++; $display("FAIL en_ptr: got %0d want 3", PTR); end
    for (int i = 0; i < 6; i++) begin
      vecs++; if (RD !== 1'b0)   begin errs++; $display("FAIL en_idle_rd[%0d]: got %b want 0", i, RD); end
      vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL en_idle_busy[%0d]: got %b want 0", i, BUSY); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    V_IN = 8'h10; EN = 1'b1; DOUT_READY = 1'b0;
    tick();
    vecs++; if (ADDR !== 3'd4) begin errs++; $display("FAIL rmid_addr: got %0d want 4", ADDR); end
    tick(); tick();
    vecs++; if (DOUT_VALID !== 1'b1) begin errs++; $display("FAIL rmid_dv: got %b want 1", DOUT_VALID); end
    RESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++; if (CLR !== 1'b0) begin errs++; $display("FAIL rmid_clr[%0d]: got %b want 0", i, CLR); end
      tick();
    end
    vecs++; if (RD !== 1'b0)         begin errs++; $display("FAIL rmid_rd: got %b want 0", RD); end
    vecs++; if (CLR !== 1'b0)        begin errs++; $display("FAIL rmid_clr_end: got %b want 0", CLR); end
    vecs++; if (DOUT_VALID !== 1'b0) begin errs++; $display("FAIL rmid_dv_end: got %b want 0", DOUT_VALID); end
    vecs++; if (DOUT !== 8'h00)      begin errs++; $display("FAIL rmid_dout: got %h want 00", DOUT); end
    vecs++; if (ADDR !== 3'd0)       begin errs++; $display("FAIL rmid_addr_end: got %0d want 0", ADDR); end
    vecs++; if (PTR !== 3'd0)        begin errs++; $display("FAIL rmid_ptr: got %0d want 0", PTR); end
    vecs++; if (BUSY !== 1'b0)       begin errs++; $display("FAIL rmid_busy: got %b want 0", BUSY); end
    EN = 1'b0; RESET = 1'b1;
    tick();
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL rmid_post_busy: got %b want 0", BUSY); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    mem[0] = 8'h0F; mem[1] = 8'h3C; mem[2] = 8'hA5; mem[4] = 8'h44;
    mem[5] = 8'h55; mem[7] = 8'h77;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
